// File: rtl/mouse_position_tracker.sv
// PS/2 mouse packet assembler: collects status/dX/dY bytes and keeps a clamped
// on-screen {X, Y} position for the display stage, plus button state and a done strobe.
module mouse_position_tracker #(
    parameter int MAX_X         = 159,
    parameter int MAX_Y         = 119,
    parameter int TIMEOUT_WIDTH = 17,
    parameter int TIMEOUT_MAX   = 99999
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [7:0]  BYTE_IN,
    input  logic        BYTE_VALID,
    input  logic        BYTE_ERROR,
    output logic [15:0] VALUE_OUT,
    output logic [2:0]  BUTTONS,
    output logic        PACKET_DONE
);

    typedef enum logic [1:0] {WAIT_STATUS, WAIT_DX, WAIT_DY} state_t;

    localparam logic signed [9:0]          W_MAX_X  = 10'(MAX_X);
    localparam logic signed [9:0]          W_MAX_Y  = 10'(MAX_Y);
    localparam logic [TIMEOUT_WIDTH-1:0]   W_TO_MAX = TIMEOUT_WIDTH'(TIMEOUT_MAX);

    state_t                   r_state;
    // {y_ovf, x_ovf, y_sign, x_sign, middle, right, left}; bit3 of the byte is only a sync marker
    logic [6:0]               r_status;
    logic [7:0]               r_dx;
    logic [7:0]               r_x;
    logic [7:0]               r_y;
    logic [2:0]               r_buttons;
    logic                     r_done;
    logic [TIMEOUT_WIDTH-1:0] r_cnt;

    logic signed [9:0]        w_dx;
    logic signed [9:0]        w_dy;
    logic signed [9:0]        w_sum_x;
    logic signed [9:0]        w_sum_y;
    logic [TIMEOUT_WIDTH-1:0] w_cnt_inc;

    function automatic logic [7:0] clamp(input logic signed [9:0] v, input logic signed [9:0] mx);
        if (v < 0)  return 8'd0;
        if (v > mx) return mx[7:0];
        return v[7:0];
    endfunction

    // dY comes straight from the incoming third byte so the packet applies on that edge
    assign w_dx      = {r_status[3], r_status[3], r_dx};
    assign w_dy      = {r_status[4], r_status[4], BYTE_IN};
    assign w_sum_x   = $signed({2'b00, r_x}) + w_dx;
    assign w_sum_y   = $signed({2'b00, r_y}) - w_dy;
    assign w_cnt_inc = r_cnt + TIMEOUT_WIDTH'(1);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state   <= WAIT_STATUS;
            r_status  <= '0;
            r_dx      <= '0;
            r_x       <= 8'(MAX_X / 2);
            r_y       <= 8'(MAX_Y / 2);
            r_buttons <= '0;
            r_done    <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_done <= 1'b0;
            if (BYTE_ERROR) begin
                r_state <= WAIT_STATUS;
                r_cnt   <= '0;
            end else if (BYTE_VALID) begin
                r_cnt <= '0;
                case (r_state)
                    WAIT_STATUS: begin
                        if (BYTE_IN[3]) begin
                            r_status <= {BYTE_IN[7:4], BYTE_IN[2:0]};
                            r_state  <= WAIT_DX;
                        end
                    end
                    WAIT_DX: begin
                        r_dx    <= BYTE_IN;
                        r_state <= WAIT_DY;
                    end
                    WAIT_DY: begin
                        if (!r_status[5]) r_x <= clamp(w_sum_x, W_MAX_X);
                        if (!r_status[6]) r_y <= clamp(w_sum_y, W_MAX_Y);
                        r_buttons <= r_status[2:0];
                        r_done    <= 1'b1;
                        r_state   <= WAIT_STATUS;
                    end
                    default: r_state <= WAIT_STATUS;
                endcase
            end else if (r_state != WAIT_STATUS) begin
                if (w_cnt_inc == W_TO_MAX) begin
                    r_state <= WAIT_STATUS;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= w_cnt_inc;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign VALUE_OUT   = {r_x, r_y};
    assign BUTTONS     = r_buttons;
    assign PACKET_DONE = r_done;

endmodule

// File: tb/tb_mouse_position_tracker.sv
// Directed bench for mouse_position_tracker: a per-cycle vector table plus
// hand-written timeout and asynchronous-reset sequences.
module tb_mouse_position_tracker;

    localparam int TO = 20;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic [7:0]  BYTE_IN = 8'h00;
    logic        BYTE_VALID = 1'b0;
    logic        BYTE_ERROR = 1'b0;
    logic [15:0] VALUE_OUT;
    logic [2:0]  BUTTONS;
    logic        PACKET_DONE;

    int n_checks = 0;
    int n_pass   = 0;

    mouse_position_tracker #(
        .MAX_X(159), .MAX_Y(119), .TIMEOUT_WIDTH(17), .TIMEOUT_MAX(TO)
    ) dut (
        .CLK(CLK), .RESET(RESET), .BYTE_IN(BYTE_IN), .BYTE_VALID(BYTE_VALID),
        .BYTE_ERROR(BYTE_ERROR), .VALUE_OUT(VALUE_OUT), .BUTTONS(BUTTONS),
        .PACKET_DONE(PACKET_DONE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        vld;
        logic        err;
        logic [7:0]  b;
        logic [15:0] val;
        logic [2:0]  btn;
        logic        done;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input logic e, input logic [7:0] b,
                       input logic [15:0] val, input logic [2:0] btn, input logic done);
        vec_t t;
        t.vld = v; t.err = e; t.b = b; t.val = val; t.btn = btn; t.done = done;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk_all(input string name, input logic [15:0] val, input logic [2:0] btn,
                           input logic done);
        chk({name, ".value"}, VALUE_OUT, val);
        chk({name, ".buttons"}, {13'd0, BUTTONS}, {13'd0, btn});
        chk({name, ".done"}, {15'd0, PACKET_DONE}, {15'd0, done});
    endtask

    task automatic drive(input logic v, input logic e, input logic [7:0] b);
        BYTE_VALID = v; BYTE_ERROR = e; BYTE_IN = b;
        @(posedge CLK); #1;
        BYTE_VALID = 1'b0; BYTE_ERROR = 1'b0; BYTE_IN = 8'h00;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        // reset state; done must stay low with no bytes
        add(0,0,8'h00, 16'h4F3B,3'd0,0); add(0,0,8'h00, 16'h4F3B,3'd0,0); add(0,0,8'h00, 16'h4F3B,3'd0,0);
        // basic packet
        add(1,0,8'h09, 16'h4F3B,3'd0,0); add(1,0,8'h0A, 16'h4F3B,3'd0,0); add(1,0,8'h05, 16'h5936,3'd1,1);
        add(0,0,8'h00, 16'h5936,3'd1,0);
        // +255 three times clamps X at 159
        for (int r = 0; r < 3; r++) begin
            add(1,0,8'h08, (r == 0) ? 16'h5936 : 16'h9F36, (r == 0) ? 3'd1 : 3'd0, 0);
            add(1,0,8'hFF, (r == 0) ? 16'h5936 : 16'h9F36, (r == 0) ? 3'd1 : 3'd0, 0);
            add(1,0,8'h00, 16'h9F36,3'd0,1);
        end
        add(0,0,8'h00, 16'h9F36,3'd0,0);
        // dX = -256 clamps X at 0
        add(1,0,8'h18, 16'h9F36,3'd0,0); add(1,0,8'h00, 16'h9F36,3'd0,0); add(1,0,8'h00, 16'h0036,3'd0,1);
        // Y overflow: Y frozen, done still pulses
        add(1,0,8'h88, 16'h0036,3'd0,0); add(1,0,8'h00, 16'h0036,3'd0,0); add(1,0,8'h7F, 16'h0036,3'd0,1);
        // X overflow: X frozen, Y moves by -3
        add(1,0,8'h48, 16'h0036,3'd0,0); add(1,0,8'h10, 16'h0036,3'd0,0); add(1,0,8'h03, 16'h0033,3'd0,1);
        // Y clamp low, then dY = -256 clamps Y high
        add(1,0,8'h08, 16'h0033,3'd0,0); add(1,0,8'h00, 16'h0033,3'd0,0); add(1,0,8'h7F, 16'h0000,3'd0,1);
        add(1,0,8'h28, 16'h0000,3'd0,0); add(1,0,8'h00, 16'h0000,3'd0,0); add(1,0,8'h00, 16'h0077,3'd0,1);
        // all buttons
        add(1,0,8'h0F, 16'h0077,3'd0,0); add(1,0,8'h00, 16'h0077,3'd0,0); add(1,0,8'h00, 16'h0077,3'd7,1);
        // resync: 00 dropped, error in WAIT_DY discards
        add(1,0,8'h00, 16'h0077,3'd7,0);
        add(1,0,8'h08, 16'h0077,3'd7,0); add(1,0,8'h01, 16'h0077,3'd7,0); add(0,1,8'h00, 16'h0077,3'd7,0);
        add(1,0,8'h08, 16'h0077,3'd7,0); add(1,0,8'h01, 16'h0077,3'd7,0); add(1,0,8'h00, 16'h0177,3'd0,1);
        // error beats a simultaneous byte; following 04 is dropped as non-status
        add(1,0,8'h08, 16'h0177,3'd0,0); add(1,0,8'h02, 16'h0177,3'd0,0); add(1,1,8'h05, 16'h0177,3'd0,0);
        add(1,0,8'h04, 16'h0177,3'd0,0);
        add(1,0,8'h08, 16'h0177,3'd0,0); add(1,0,8'h02, 16'h0177,3'd0,0); add(1,0,8'h00, 16'h0377,3'd0,1);
        // error in WAIT_DX
        add(1,0,8'h08, 16'h0377,3'd0,0); add(0,1,8'h00, 16'h0377,3'd0,0);
        add(1,0,8'h08, 16'h0377,3'd0,0); add(1,0,8'h03, 16'h0377,3'd0,0); add(1,0,8'h00, 16'h0677,3'd0,1);
        add(0,0,8'h00, 16'h0677,3'd0,0);

        #12 RESET = 1'b1;
        @(posedge CLK); #1;
        chk_all("reset", 16'h4F3B, 3'd0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].vld, vecs[i].err, vecs[i].b);
            chk_all($sformatf("vec%0d", i), vecs[i].val, vecs[i].btn, vecs[i].done);
        end

        // timeout discards the partial packet
        RESET = 1'b0; #3; RESET = 1'b1;
        @(posedge CLK); #1;
        drive(1,0,8'h08); drive(1,0,8'h05);
        idle(TO);
        drive(1,0,8'h08); drive(1,0,8'h02); drive(1,0,8'h00);
        chk_all("timeout", 16'h513B, 3'd0, 1'b1);

        // one cycle short of the timeout: packet survives
        drive(1,0,8'h08); drive(1,0,8'h05);
        idle(TO - 1);
        drive(1,0,8'h00);
        chk_all("no_timeout", 16'h563B, 3'd0, 1'b1);

        // asynchronous reset mid-packet, observed without a clock edge
        drive(1,0,8'h08); drive(1,0,8'h01);
        #2 RESET = 1'b0;
        #1 chk_all("async_rst", 16'h4F3B, 3'd0, 1'b0);
        #3 RESET = 1'b1;
        @(posedge CLK); #1;
        drive(1,0,8'h09); drive(1,0,8'h0A); drive(1,0,8'h05);
        chk_all("post_rst", 16'h5936, 3'd1, 1'b1);
        idle(1);
        chk_all("post_rst_idle", 16'h5936, 3'd1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mouse_position_tracker.md
Name: mouse_position_tracker

Overview:
- Sits directly upstream of the segment/LED display stage. Consumes PS/2 mouse bytes from the mouse receiver and assembles them into 3-byte packets (status, dX, dY).
- Accumulates a clamped on-screen X/Y position and presents it as a 16-bit word, {X, Y}, on the display stage's value input.
- Also exposes the button state and a packet-done strobe.

Parameters:
MAX_X, 159, inclusive upper bound of X position (0..255)
MAX_Y, 119, inclusive upper bound of Y position (0..255)
TIMEOUT_WIDTH, 17, width of inter-byte timeout counter
TIMEOUT_MAX, 99999, cycles without a byte before partial packet is discarded

Ports:
CLK  input  1  system clock, all state on rising edge
RESET  input  1  asynchronous, active-low reset
BYTE_IN  input  8  received mouse byte, valid only with BYTE_VALID
BYTE_VALID  input  1  one-cycle strobe, BYTE_IN is a new byte
BYTE_ERROR  input  1  one-cycle strobe, receiver parity/framing error
VALUE_OUT  output  16  {X[7:0], Y[7:0]} position, feeds display stage value input
BUTTONS  output  3  {middle, right, left} from last accepted status byte
PACKET_DONE  output  1  one-cycle pulse when a full packet has been applied

Behaviour:
- Reset (RESET low, asynchronous):
  - state = WAIT_STATUS.
  - X = MAX_X/2 (integer division), Y = MAX_Y/2. Defaults give VALUE_OUT = 16'h4F3B.
  - BUTTONS = 3'b000, PACKET_DONE = 0, timeout counter = 0, holding registers = 0.
- FSM states: WAIT_STATUS, WAIT_DX, WAIT_DY.
  - WAIT_STATUS: on BYTE_VALID with BYTE_IN[3]=1, latch status and go to WAIT_DX. If BYTE_IN[3]=0, the byte is dropped and the state stays (resync).
  - WAIT_DX: on BYTE_VALID, latch dX and go to WAIT_DY.
  - WAIT_DY: on BYTE_VALID, apply the packet on that same edge and go to WAIT_STATUS.
- Status byte fields:
  - bit0 left, bit1 right, bit2 middle.
  - bit4 X sign, bit5 Y sign.
  - bit6 X overflow, bit7 Y overflow.
- Delta arithmetic:
  - Delta is 9-bit two's complement {sign, byte}, range -256..+255.
  - Sum is computed at 10 bits signed: newX = X + dX; newY = Y - dY (mouse up decreases screen Y).
  - Clamp: result < 0 gives 0; result > MAX gives MAX. No wrap-around.
- Overflow:
  - If the X overflow bit is set, X is unchanged for that packet. Y behaves the same with its own overflow bit.
  - BUTTONS is still updated.
- Latency:
  - VALUE_OUT, BUTTONS and PACKET_DONE update on the edge that accepts the third byte, so they are visible in the following cycle.
  - PACKET_DONE is high for exactly one cycle.
- Error handling:
  - BYTE_ERROR in any state returns the FSM to WAIT_STATUS and discards the partial packet. Position and BUTTONS are unchanged.
  - If BYTE_ERROR and BYTE_VALID arrive in the same cycle, the error wins and the byte is ignored.
- Timeout:
  - The counter runs only in WAIT_DX and WAIT_DY, and clears on every BYTE_VALID.
  - When it reaches TIMEOUT_MAX, the FSM returns to WAIT_STATUS, the partial packet is dropped and the counter clears.
  - If the timeout and BYTE_VALID occur in the same cycle, the byte wins and is processed normally.
- Idle: in WAIT_STATUS the counter is held at 0.
- Outputs are fully registered, with no combinational path from BYTE_IN to VALUE_OUT.
- Reset asserted mid-packet clears everything immediately. The first byte after reset release is treated as a status candidate.

Test Plan:
- Reset release, no bytes -> VALUE_OUT = 16'h4F3B, BUTTONS = 0, PACKET_DONE never pulses.
- Packet 8'h09, 8'h0A, 8'h05 -> next cycle: PACKET_DONE = 1 for one cycle, VALUE_OUT = {8'd89, 8'd54}, BUTTONS = 3'b001.
- Saturation at the X bound:
  - Packet 8'h08, 8'hFF, 8'h00, sent three times -> X clamps at 159, VALUE_OUT[15:8] = 8'h9F.
  - Then 8'h18, 8'h00, 8'h00 (dX = -256) -> X = 0.
- Y overflow: packet 8'h88, 8'h00, 8'h7F -> Y unchanged at 59, PACKET_DONE still pulses.
- Resync:
  - Byte 8'h00 in WAIT_STATUS is ignored.
  - Then 8'h08, 8'h01 followed by a BYTE_ERROR -> no update.
  - A following valid packet 8'h08, 8'h01, 8'h00 -> X = 80.
- Timeout:
  - Send 8'h08, 8'h05, then idle TIMEOUT_MAX cycles, then 8'h08, 8'h02, 8'h00 -> X = 81 (the first partial packet is discarded).
  - Repeat with RESET pulsed low mid-packet -> VALUE_OUT returns to 16'h4F3B asynchronously.
